// File: rtl/if_id_skid_if.sv
// rtl/if_id_skid_if.sv - handshake bundle between fetch, the IF/ID skid stage and decode
//
// Signals:
//   inValid/inReady/inPC/inInstr   fetch -> stage handshake and payload
//   flush                          discard everything buffered (taken branch)
//   outValid/outReady/outPC/outInstr  stage -> decode handshake and payload
//   outRn/outRm/outRt              register fields of outInstr for the Reg2Loc mux
// Modports: slave (the skid stage), master (fetch/decode side driving it)
interface if_id_skid_if #(
   parameter int PC_WIDTH = 64
);
   logic                inValid;
   logic                inReady;
   logic [PC_WIDTH-1:0] inPC;
   logic [31:0]         inInstr;
   logic                flush;
   logic                outValid;
   logic                outReady;
   logic [PC_WIDTH-1:0] outPC;
   logic [31:0]         outInstr;
   logic [4:0]          outRn;
   logic [4:0]          outRm;
   logic [4:0]          outRt;

   modport slave (
      input  inValid, inPC, inInstr, flush, outReady,
      output inReady, outValid, outPC, outInstr, outRn, outRm, outRt
   );

   modport master (
      output inValid, inPC, inInstr, flush, outReady,
      input  inReady, outValid, outPC, outInstr, outRn, outRm, outRt
   );
endinterface

// File: rtl/if_id_skid.sv
// rtl/if_id_skid.sv - two-entry IF/ID pipeline register with skid buffer
//
// Optional feature macro: IF_ID_STALL_CNT_EN adds the stallCount output.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   bus         if_id_skid_if.slave: fetch handshake, flush, decode handshake,
//               decoded register fields outRn/outRm/outRt
//   stallCount  (IF_ID_STALL_CNT_EN only) saturating count of cycles with
//               inValid=1 and inReady=0; cleared by reset only
module if_id_skid #(
   parameter int PC_WIDTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   if_id_skid_if.slave bus
`ifdef IF_ID_STALL_CNT_EN
   ,
   output logic [31:0] stallCount
`endif
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   // Skid validity is implied by state TWO; head validity is mirrored in
   // out_valid_q so outValid comes straight from a flop.
   state_t              state_q;
   logic                out_valid_q;
   logic                in_ready_q;
   logic [PC_WIDTH-1:0] head_pc_q;
   logic [31:0]         head_instr_q;
   logic [PC_WIDTH-1:0] skid_pc_q;
   logic [31:0]         skid_instr_q;

   logic in_xfer;
   logic out_xfer;

   assign in_xfer  = bus.inValid & in_ready_q;
   assign out_xfer = out_valid_q & bus.outReady;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= EMPTY;
         out_valid_q  <= 1'b0;
         in_ready_q   <= 1'b1;
         head_pc_q    <= '0;
         head_instr_q <= '0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
      end else if (bus.flush) begin
         // Flush wins over any transfer; the presented input is dropped.
         state_q      <= EMPTY;
         out_valid_q  <= 1'b0;
         in_ready_q   <= 1'b1;
         head_pc_q    <= '0;
         head_instr_q <= '0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_xfer) begin
                  head_pc_q    <= bus.inPC;
                  head_instr_q <= bus.inInstr;
                  out_valid_q  <= 1'b1;
                  state_q      <= ONE;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  head_pc_q    <= bus.inPC;
                  head_instr_q <= bus.inInstr;
               end else if (in_xfer) begin
                  // Decode stalled: park the newcomer and close the input
                  // next cycle, so inReady never looks at outReady.
                  skid_pc_q    <= bus.inPC;
                  skid_instr_q <= bus.inInstr;
                  in_ready_q   <= 1'b0;
                  state_q      <= TWO;
               end else if (out_xfer) begin
                  // Head contents are kept so outPC/outInstr show the last entry.
                  out_valid_q  <= 1'b0;
                  state_q      <= EMPTY;
               end
            end
            TWO: begin
               // inReady is low here, so only an output transfer can happen.
               if (out_xfer) begin
                  head_pc_q    <= skid_pc_q;
                  head_instr_q <= skid_instr_q;
                  in_ready_q   <= 1'b1;
                  state_q      <= ONE;
               end
            end
            default: begin
               state_q     <= EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.inReady  = in_ready_q;
   assign bus.outValid = out_valid_q;
   assign bus.outPC    = head_pc_q;
   assign bus.outInstr = head_instr_q;
   // Register-select fields; Reg2Loc picks Rm on select 0 and Rt on select 1.
   assign bus.outRn    = head_instr_q[9:5];
   assign bus.outRm    = head_instr_q[20:16];
   assign bus.outRt    = head_instr_q[4:0];

`ifdef IF_ID_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (bus.inValid && !in_ready_q && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// tb/tb_if_id_skid.sv - self-checking bench for if_id_skid
module tb_if_id_skid;
   localparam int PW = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   if_id_skid_if #(.PC_WIDTH(PW)) bus ();

`ifdef IF_ID_STALL_CNT_EN
   logic [31:0] stall_count;
`endif

   if_id_skid #(.PC_WIDTH(PW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef IF_ID_STALL_CNT_EN
      ,
      .stallCount (stall_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of at most two instructions. Acceptance next
   // cycle is allowed whenever fewer than two are held.
   logic [PW-1:0] m_pc[$];
   logic [31:0]   m_ins[$];
   bit            m_rdy;
   logic [PW-1:0] m_last_pc;
   logic [31:0]   m_last_ins;
   longint        m_stalls;

   task automatic model_reset();
      m_pc.delete();
      m_ins.delete();
      m_rdy      = 1'b1;
      m_last_pc  = '0;
      m_last_ins = '0;
      m_stalls   = 0;
   endtask

   task automatic model_step();
      bit in_x;
      bit out_x;
      if (bus.inValid && !m_rdy && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (bus.flush) begin
         m_pc.delete();
         m_ins.delete();
         m_rdy      = 1'b1;
         m_last_pc  = '0;
         m_last_ins = '0;
      end else begin
         in_x  = bus.inValid && m_rdy;
         out_x = (m_pc.size() > 0) && bus.outReady;
         if (out_x) begin
            void'(m_pc.pop_front());
            void'(m_ins.pop_front());
         end
         if (in_x) begin
            m_pc.push_back(bus.inPC);
            m_ins.push_back(bus.inInstr);
         end
         m_rdy = (m_pc.size() < 2);
         if (m_pc.size() > 0) begin
            m_last_pc  = m_pc[0];
            m_last_ins = m_ins[0];
         end
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [31:0] ins;
      ins = m_last_ins;
      check({tag, ".outValid"}, 64'(bus.outValid), 64'(m_pc.size() > 0));
      check({tag, ".inReady"},  64'(bus.inReady),  64'(m_rdy));
      check({tag, ".outPC"},    64'(bus.outPC),    64'(m_last_pc));
      check({tag, ".outInstr"}, 64'(bus.outInstr), 64'(ins));
      check({tag, ".outRn"},    64'(bus.outRn),    64'(ins[9:5]));
      check({tag, ".outRm"},    64'(bus.outRm),    64'(ins[20:16]));
      check({tag, ".outRt"},    64'(bus.outRt),    64'(ins[4:0]));
   endtask

   task automatic drive(input logic iv, input logic [63:0] pc, input logic [31:0] ins,
                        input logic fl, input logic ordy);
      bus.inValid  = iv;
      bus.inPC     = pc;
      bus.inInstr  = ins;
      bus.flush    = fl;
      bus.outReady = ordy;
   endtask

   typedef struct {
      logic        iv;
      logic [63:0] pc;
      logic [31:0] ins;
      logic        fl;
      logic        ordy;
      logic        e_ov;
      logic        e_ir;
      logic [63:0] e_pc;
      logic [31:0] e_ins;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic [31:0] e;
      // Basic transfer
      tbl[0]  = '{1'b1, 64'h100, 32'h8B02_0020, 1'b0, 1'b1, 1'b1, 1'b1, 64'h100, 32'h8B02_0020};
      tbl[1]  = '{1'b0, 64'h0,   32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 64'h100, 32'h8B02_0020};
      // Backpressure: third instruction refused, then drained in order
      tbl[2]  = '{1'b1, 64'h0,   32'h1111_0000, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0,   32'h1111_0000};
      tbl[3]  = '{1'b1, 64'h4,   32'h1111_0004, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   32'h1111_0000};
      tbl[4]  = '{1'b1, 64'h8,   32'h1111_0008, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,   32'h1111_0000};
      tbl[5]  = '{1'b1, 64'h8,   32'h1111_0008, 1'b0, 1'b1, 1'b1, 1'b1, 64'h4,   32'h1111_0004};
      tbl[6]  = '{1'b1, 64'h8,   32'h1111_0008, 1'b0, 1'b1, 1'b1, 1'b1, 64'h8,   32'h1111_0008};
      tbl[7]  = '{1'b0, 64'h0,   32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 64'h8,   32'h1111_0008};
      // Flush from TWO with a competing input
      tbl[8]  = '{1'b1, 64'h10,  32'h2222_0010, 1'b0, 1'b0, 1'b1, 1'b1, 64'h10,  32'h2222_0010};
      tbl[9]  = '{1'b1, 64'h14,  32'h2222_0014, 1'b0, 1'b0, 1'b1, 1'b0, 64'h10,  32'h2222_0010};
      tbl[10] = '{1'b1, 64'h40,  32'h3333_0040, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0,   32'h0};
      tbl[11] = '{1'b0, 64'h0,   32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 64'h0,   32'h0};

      drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
      reset = 1'b1;
      #2;
      check("reset.outValid", 64'(bus.outValid), 64'd0);
      check("reset.inReady",  64'(bus.inReady),  64'd1);
      check("reset.outPC",    64'(bus.outPC),    64'd0);
      check("reset.outInstr", 64'(bus.outInstr), 64'd0);
      check("reset.fields",   64'({bus.outRn, bus.outRm, bus.outRt}), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();

      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].iv, tbl[i].pc, tbl[i].ins, tbl[i].fl, tbl[i].ordy);
         step();
         e = tbl[i].e_ins;
         check($sformatf("vec%0d.outValid", i), 64'(bus.outValid), 64'(tbl[i].e_ov));
         check($sformatf("vec%0d.inReady", i),  64'(bus.inReady),  64'(tbl[i].e_ir));
         check($sformatf("vec%0d.outPC", i),    64'(bus.outPC),    tbl[i].e_pc);
         check($sformatf("vec%0d.outInstr", i), 64'(bus.outInstr), 64'(e));
         check($sformatf("vec%0d.outRm", i),    64'(bus.outRm),    64'(e[20:16]));
         if (i == 0) begin
            check("basic.outRm", 64'(bus.outRm), 64'd2);
            check("basic.outRn", 64'(bus.outRn), 64'd1);
            check("basic.outRt", 64'(bus.outRt), 64'd0);
         end
      end

      // Throughput: one transfer per cycle, never stalling
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 64'(4 * k), 32'h4444_0000 + 32'(k), 1'b0, 1'b1);
         step();
         check($sformatf("thru%0d.inReady", k),  64'(bus.inReady),  64'd1);
         check($sformatf("thru%0d.outValid", k), 64'(bus.outValid), 64'd1);
         check($sformatf("thru%0d.outPC", k),    64'(bus.outPC),    64'(4 * k));
      end
      drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
      step();
      check_model("thru_end");

      // Asynchronous reset from TWO, between edges
      drive(1'b1, 64'h50, 32'h5555_0050, 1'b0, 1'b0);
      step();
      drive(1'b1, 64'h54, 32'h5555_0054, 1'b0, 1'b0);
      step();
      check("two.inReady", 64'(bus.inReady), 64'd0);
      #2;
      reset = 1'b1;
      #1;
      check("areset.outValid", 64'(bus.outValid), 64'd0);
      check("areset.inReady",  64'(bus.inReady),  64'd1);
      check("areset.outPC",    64'(bus.outPC),    64'd0);
      #1;
      reset = 1'b0;
      drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
      model_reset();

      // Fill two entries, then stall five cycles, then flush
      for (int k = 0; k < 7; k++) begin
         drive(1'b1, 64'h60 + 64'(4 * k), 32'h6666_0000 + 32'(k), 1'b0, 1'b0);
         step();
      end
      check_model("stall");
`ifdef IF_ID_STALL_CNT_EN
      check("stallCount.5", 64'(stall_count), 64'd5);
`endif
      drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      step();
      drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
      check_model("stall_flush");
`ifdef IF_ID_STALL_CNT_EN
      check("stallCount.flush", 64'(stall_count), 64'd5);
`endif

      // Randomized traffic against the FIFO model
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom,
               $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
         step();
         check_model($sformatf("rand%0d", c));
`ifdef IF_ID_STALL_CNT_EN
         check($sformatf("rand%0d.stallCount", c), 64'(stall_count), 64'(m_stalls));
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 The module SHALL have a parameter PC_WIDTH, default 64, giving the program-counter width in bits.
REQ-002 The module SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have a port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have a port inValid, input, 1 bit: the fetch stage presents a valid instruction.
REQ-005 The module SHALL have a port inReady, output, 1 bit: this stage can accept an instruction this cycle.
REQ-006 The module SHALL have a port inPC, input, PC_WIDTH bits: PC of the presented instruction.
REQ-007 The module SHALL have a port inInstr, input, 32 bits: the presented instruction word.
REQ-008 The module SHALL have a port flush, input, 1 bit: discard all buffered instructions (branch taken).
REQ-009 The module SHALL have a port outValid, output, 1 bit: the head entry is valid for decode.
REQ-010 The module SHALL have a port outReady, input, 1 bit: decode consumes the head entry this cycle.
REQ-011 The module SHALL have a port outPC, output, PC_WIDTH bits: PC of the head entry.
REQ-012 The module SHALL have a port outInstr, output, 32 bits: instruction word of the head entry.
REQ-013 The module SHALL have ports outRn, outRm and outRt, each output, 5 bits: fields [9:5], [20:16] and [4:0] of outInstr, driven combinationally and feeding the Reg2Loc register-select mux (Rm on select 0, Rt on select 1).

Function
REQ-014 The module SHALL hold two entries, head and skid, each with {valid, PC, instr}, and SHALL be in one of three states: EMPTY (0 entries), ONE (head only) or TWO (head and skid).
REQ-015 inReady SHALL be a registered signal equal to NOT skid-valid; it SHALL NOT depend combinationally on outReady.
REQ-016 An input transfer SHALL occur when inValid and inReady are both 1; an output transfer SHALL occur when outValid and outReady are both 1.
REQ-017 outValid SHALL equal head-valid; outPC and outInstr SHALL equal the head contents.
REQ-018 The state transitions SHALL be as follows:
- EMPTY with an input transfer -> ONE; the input is written to head, and outValid is 1 on the next cycle (latency 1).
- ONE with an input transfer and an output transfer -> ONE; the input is written to head.
- ONE with an input transfer and no output transfer -> TWO; the input is written to skid.
- ONE with an output transfer only -> EMPTY.
- TWO with an output transfer -> ONE; skid moves to head.
- TWO with no output transfer -> TWO; contents are held.
REQ-019 Order SHALL be strictly FIFO; no instruction is dropped or duplicated except by flush.
REQ-020 flush SHALL have priority over every other event: the next state is EMPTY, both entries are invalid with PC and instr zeroed, and any input presented in the flush cycle is discarded.
REQ-021 inReady SHALL be 1 in the cycle after a flush.
REQ-022 When outValid is 0, outPC and outInstr SHALL hold zero after reset or flush, and otherwise SHALL hold the last head contents.

Reset
REQ-023 On reset asserted, the module SHALL immediately, without waiting for clk, enter EMPTY and drive outValid=0, inReady=1, outPC=0, outInstr=0 and outRn/outRm/outRt=0.
REQ-024 A reset asserted mid-operation SHALL discard all buffered entries; operation SHALL resume on the first clk edge after reset deasserts.

Configuration
REQ-025 With macro IF_ID_STALL_CNT_EN defined, the module SHALL add an output port stallCount, 32 bits, which increments by 1 on each cycle in which inValid=1 and inReady=0, saturates at 0xFFFFFFFF, is cleared by reset, and is not cleared by flush.
REQ-026 With IF_ID_STALL_CNT_EN undefined, the stallCount port and its counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 Basic transfer: reset, then inValid=1 for one cycle with inPC=0x100, inInstr=0x8B020020, outReady=1 -> next cycle outValid=1, outPC=0x100, outRm=2, outRn=1, outRt=0.
REQ-028 Backpressure: outReady=0 while three consecutive instructions (PC 0x0, 0x4, 0x8) are presented -> the first two are accepted and inReady=0 from the third cycle; then outReady=1 -> outputs appear in order 0x0, 0x4, 0x8.
REQ-029 Throughput: outReady=1 and inValid=1 held for 10 cycles with PC 0x0 to 0x24 -> 10 output transfers on consecutive cycles and inReady is 1 throughout.
REQ-030 Flush: in state TWO, flush=1 with inValid=1 and inPC=0x40 -> next cycle outValid=0, inReady=1, outInstr=0, and 0x40 never appears at the output.
REQ-031 Asynchronous reset: reset is pulsed between clk edges in state TWO -> outValid=0 and inReady=1 before the next edge.
REQ-032 Stall counter (IF_ID_STALL_CNT_EN defined): inValid=1 held with inReady=0 for 5 cycles -> stallCount=5, and stallCount is still 5 after a subsequent flush.
